alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 2-bit-opcode combinational ALU. It is generalised to WIDTH bits and an 8-op 3-bit opcode, including an iterative shift-add multiply. Results and flags are registered behind a valid/ready interface, so the block can sit between a decode stage and writeback in the multi-cycle datapath. Carry and overflow are defined correctly for both ADD and SUB.

Parameters:
WIDTH, 32, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
clk        input   1      system clock; all state updates on its rising edge
rst        input   1      reset, synchronous and active-high
in_valid   input   1      operands and op presented
in_ready   output  1      block can accept an operation
a          input   WIDTH  operand A
b          input   WIDTH  operand B
op         input   3      operation select (encoding below)
out_valid  output  1      result and flags valid
out_ready  input   1      consumer takes the result
result     output  WIDTH  operation result
zero       output  1      result == 0
overflow   output  1      signed overflow (ADD/SUB only)
cout       output  1      carry-out (ADD) / no-borrow (SUB)

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 011 SUB (identical to the legacy 2-bit codes zero-extended).
  - 100 XOR, 101 SLT (signed), 110 SLTU (unsigned).
  - 111 MUL: low WIDTH bits of a*b.
- States: IDLE, MUL_BUSY, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: an operation is accepted when in_valid && in_ready. a, b and op are sampled on that edge only; later input changes are ignored.
- Single-cycle ops (000-110):
  - result and flags are registered on the accept edge; state goes to DONE.
  - out_valid is high the cycle after accept, i.e. latency 1.
- MUL:
  - The accept edge loads mcand = a, mplier = b, acc = 0, cnt = 0; state goes to MUL_BUSY.
  - Each MUL_BUSY cycle: if mplier[0], acc += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; cnt++.
  - After WIDTH iterations: result = acc, state goes to DONE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge. There is no early termination.
- DONE:
  - result and flags are held stable while out_ready = 0.
  - On out_ready = 1: state goes to IDLE; out_valid drops the next cycle.
  - No bypass: a new op can be accepted at the earliest the cycle after the handshake. Maximum throughput is therefore 1 op per 2 cycles.
- ADD/SUB arithmetic:
  - Computed as a WIDTH+1-bit sum a + (b ^ {WIDTH{sub}}) + sub.
  - cout = bit WIDTH of that sum. For SUB this means cout = 1 iff a >= b unsigned.
  - overflow = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is the inverted b for SUB.
- Other flags:
  - overflow and cout are 0 for all ops other than ADD/SUB.
  - zero = ~|result for every op, MUL included.
- SLT/SLTU: result = {WIDTH-1 zeros, lt}.
- Reset:
  - state = IDLE; result = 0; zero = 1; overflow = 0; cout = 0; out_valid = 0; in_ready = 1 from the first cycle after reset.
  - Reset mid-MUL or in DONE discards the operation and produces no output.
- rst dominates: if rst and in_valid are both high, nothing is accepted.
- An out_ready pulse while out_valid = 0 is ignored.

Decomposition:
- Package alu_pkg holds:
  - op localparams OP_AND..OP_MUL (3 bits);
  - state encoding (IDLE/MUL_BUSY/DONE);
  - a counter-width function, $clog2(WIDTH)+1.
- One natural sub-module: alu_seq_mul, the iterative multiplier.
  - Ports: clk, rst, start, a, b, done, product.
  - The top-level FSM sequences it and owns the output registers.
- All single-cycle logic stays combinational inside alu_seq, feeding the output registers.

Test Plan:
- Test 1, ADD overflow: WIDTH=32, ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, cout=0, zero=0, out_valid 1 cycle after accept.
- Test 2, ADD carry and SUB equal operands:
  - ADD a=0xFFFFFFFF, b=1 -> result 0, zero=1, cout=1, overflow=0.
  - SUB a=5, b=5 -> result 0, zero=1, cout=1.
- Test 3, SUB borrow and compares: SUB a=3, b=5 -> result 0xFFFFFFFE, cout=0, overflow=0. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0.
- Test 4, MUL: MUL a=12345, b=678 -> result 8369910, out_valid exactly 33 cycles after accept, in_ready=0 throughout. MUL a=0x10000, b=0x10000 -> result 0, zero=1.
- Test 5, backpressure: hold out_ready=0 for 10 cycles after AND a=0xF0F0F0F0, b=0xFF00FF00 -> result 0xF000F000 stable, in_ready=0, changes on a/b/op ignored. Raise out_ready -> IDLE next cycle.
- Test 6, reset mid-MUL: assert rst 10 cycles into a MUL -> next cycle out_valid=0, in_ready=1, result=0, zero=1. A subsequent OR a=1, b=2 -> 3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and counter sizing shared by alu_seq and alu_seq_mul
package alu_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per cycle, WIDTH cycles per product
// ports: clk, rst (sync, active-high), start loads a/b, done is high on the last iteration cycle
// together with the final product (combinational, so the caller registers it on that edge)
module alu_seq_mul import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0] cnt;
  logic busy;
  // accumulator value after the current iteration; equals the final product on the done cycle
  assign product = mplier[0] ? acc + mcand : acc;
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      acc <= '0;
      mcand <= a;
      mplier <= b;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt + CW'(1);
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU (AND/OR/ADD/SUB/XOR/SLT/SLTU/MUL) with registered result and flags
// ports: clk, rst (sync, active-high); in_valid/in_ready accept a, b, op;
// out_valid/out_ready return result, zero, overflow, cout
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);
  state_t state;
  logic sub, arith, lt_s, lt_u, ov_c, co_c, mul_done;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] bx, res_c, product;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // SUB reuses the adder as a + ~b + 1, so cout reads as "no borrow"
  always_comb begin
    sub = op == OP_SUB;
    arith = sub || op == OP_ADD;
    bx = b ^ {WIDTH{sub}};
    sum = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    res_c = op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            arith        ? sum[WIDTH-1:0] :
            op == OP_XOR ? a ^ b :
            op == OP_SLT ? WIDTH'(lt_s) : WIDTH'(lt_u);
    ov_c = arith && a[WIDTH-1] == bx[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
    co_c = arith && sum[WIDTH];
  end
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(in_ready && in_valid && op == OP_MUL),
    .a(a),
    .b(b),
    .done(mul_done),
    .product(product)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      result <= '0;
      zero <= 1'b1;
      overflow <= 1'b0;
      cout <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      state <= op == OP_MUL ? MUL_BUSY : DONE;
      if (op != OP_MUL) begin
        result <= res_c;
        zero <= ~|res_c;
        overflow <= ov_c;
        cout <= co_c;
      end
    end else if (state == MUL_BUSY && mul_done) begin
      state <= DONE;
      result <= product;
      zero <= ~|product;
      overflow <= 1'b0;
      cout <= 1'b0;
    end else if (state == DONE && out_ready)
      state <= IDLE;
endmodule
